// File: rtl/dsi_lane_hs_sequencer.sv
// rtl/dsi_lane_hs_sequencer.sv - per-lane MIPI DSI LP/HS burst sequencer feeding an 8:1 serializer
module dsi_lane_hs_sequencer #(
  parameter int unsigned T_LPX        = 2,
  parameter int unsigned T_HS_PREPARE = 3,
  parameter int unsigned T_HS_ZERO    = 4,
  parameter int unsigned T_HS_TRAIL   = 3,
  parameter int unsigned T_HS_EXIT    = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] serdes_data,
  output logic       serdes_t,
  output logic       lp_p,
  output logic       lp_n,
  output logic       hs_active,
  output logic       err_underflow
);

  typedef enum logic [2:0] {IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT} state_t;

  localparam logic [7:0] LPX_LD   = 8'(T_LPX - 1);
  localparam logic [7:0] PREP_LD  = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0] ZERO_LD  = 8'(T_HS_ZERO - 1);
  localparam logic [7:0] TRAIL_LD = 8'(T_HS_TRAIL - 1);
  localparam logic [7:0] EXIT_LD  = 8'(T_HS_EXIT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       last_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      last_bit      <= 1'b0;
      in_ready      <= 1'b0;
      serdes_data   <= 8'h00;
      serdes_t      <= 1'b1;
      lp_p          <= 1'b1;
      lp_n          <= 1'b1;
      hs_active     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= LPX;
            cnt       <= LPX_LD;
            lp_p      <= 1'b0;
            lp_n      <= 1'b1;
            hs_active <= 1'b1;
          end
        end
        LPX: begin
          if (cnt == 8'd0) begin
            state <= PREP;
            cnt   <= PREP_LD;
            lp_n  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PREP: begin
          if (cnt == 8'd0) begin
            state       <= ZERO;
            cnt         <= ZERO_LD;
            serdes_t    <= 1'b0;
            serdes_data <= 8'h00;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ZERO: begin
          if (cnt == 8'd0) begin
            state       <= SYNC;
            serdes_data <= SYNC_BYTE;
            in_ready    <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SYNC: begin
          if (in_valid) begin
            state       <= DATA;
            serdes_data <= in_data;
            last_bit    <= in_data[7];
            in_ready    <= ~in_last;
          end else begin
            // Nothing to send: the sync word itself is the last HS bit before trail
            state         <= TRAIL;
            cnt           <= TRAIL_LD;
            in_ready      <= 1'b0;
            err_underflow <= 1'b1;
            last_bit      <= SYNC_BYTE[7];
            serdes_data   <= {8{~SYNC_BYTE[7]}};
          end
        end
        DATA: begin
          // in_ready low here means the final byte is on the wire this cycle
          if (!in_ready) begin
            state       <= TRAIL;
            cnt         <= TRAIL_LD;
            serdes_data <= {8{~last_bit}};
          end else if (in_valid) begin
            serdes_data <= in_data;
            last_bit    <= in_data[7];
            in_ready    <= ~in_last;
          end else begin
            state         <= TRAIL;
            cnt           <= TRAIL_LD;
            in_ready      <= 1'b0;
            err_underflow <= 1'b1;
            serdes_data   <= {8{~last_bit}};
          end
        end
        TRAIL: begin
          if (cnt == 8'd0) begin
            state       <= EXIT;
            cnt         <= EXIT_LD;
            serdes_t    <= 1'b1;
            serdes_data <= 8'h00;
            lp_p        <= 1'b1;
            lp_n        <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        EXIT: begin
          if (cnt == 8'd0) begin
            state     <= IDLE;
            hs_active <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsi_lane_hs_sequencer.sv
// tb/tb_dsi_lane_hs_sequencer.sv - scoreboard bench for dsi_lane_hs_sequencer (default, all-1 and all-255 timing)
module tb_dsi_lane_hs_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_last;
  logic [7:0] in_data;
  logic [1:0] sel;

  logic [7:0] sd  [0:2];
  logic       st  [0:2];
  logic       lpp [0:2];
  logic       lpn [0:2];
  logic       rdy [0:2];
  logic       hsa [0:2];
  logic       er  [0:2];

  dsi_lane_hs_sequencer u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd0)), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy[0]), .serdes_data(sd[0]), .serdes_t(st[0]), .lp_p(lpp[0]), .lp_n(lpn[0]),
    .hs_active(hsa[0]), .err_underflow(er[0]));

  dsi_lane_hs_sequencer #(.T_LPX(1), .T_HS_PREPARE(1), .T_HS_ZERO(1), .T_HS_TRAIL(1), .T_HS_EXIT(1)) u_min (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd1)), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy[1]), .serdes_data(sd[1]), .serdes_t(st[1]), .lp_p(lpp[1]), .lp_n(lpn[1]),
    .hs_active(hsa[1]), .err_underflow(er[1]));

  dsi_lane_hs_sequencer #(.T_LPX(255), .T_HS_PREPARE(255), .T_HS_ZERO(255), .T_HS_TRAIL(255), .T_HS_EXIT(255)) u_max (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2'd2)), .in_data(in_data), .in_last(in_last),
    .in_ready(rdy[2]), .serdes_data(sd[2]), .serdes_t(st[2]), .lp_p(lpp[2]), .lp_n(lpn[2]),
    .hs_active(hsa[2]), .err_underflow(er[2]));

  logic [7:0] m_sd;
  logic       m_st, m_lpp, m_lpn, m_rdy, m_hs, m_er;
  always_comb begin
    m_sd  = sd[sel];
    m_st  = st[sel];
    m_lpp = lpp[sel];
    m_lpn = lpn[sel];
    m_rdy = rdy[sel];
    m_hs  = hsa[sel];
    m_er  = er[sel];
  end

  int t_lpx   [0:2] = '{2, 1, 255};
  int t_prep  [0:2] = '{3, 1, 255};
  int t_zero  [0:2] = '{4, 1, 255};
  int t_trail [0:2] = '{3, 1, 255};
  int t_exit  [0:2] = '{2, 1, 255};

  // Phase code is {lp_p, lp_n, serdes_t, hs_active}; len < 0 means any length
  localparam logic [3:0] PH_IDLE = 4'b1110;
  localparam logic [3:0] PH_LPX  = 4'b0111;
  localparam logic [3:0] PH_PREP = 4'b0011;
  localparam logic [3:0] PH_HS   = 4'b0001;
  localparam logic [3:0] PH_EXIT = 4'b1111;

  typedef struct { logic [3:0] ph; int len; } run_t;
  typedef struct { logic [7:0] d; logic r; logic e; } word_t;

  run_t  run_q  [$];
  word_t word_q [$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;
  logic [7:0] pay [0:7];

  initial begin : monitor
    logic [3:0] cur_ph, ph;
    int    cur_len;
    run_t  r;
    word_t w;
    cur_ph  = 4'b0000;
    cur_len = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        ph = {m_lpp, m_lpn, m_st, m_hs};
        if (cur_len == 0 || ph !== cur_ph) begin
          if (cur_len != 0) begin
            vectors++;
            if (run_q.size() == 0) begin
              miscompares++;
              $display("FAIL run_unexpected: phase %b len %0d, none required", cur_ph, cur_len);
            end else begin
              r = run_q.pop_front();
              if (r.ph !== cur_ph || (r.len >= 0 && r.len != cur_len)) begin
                miscompares++;
                $display("FAIL run: phase %b len %0d, required phase %b len %0d", cur_ph, cur_len, r.ph, r.len);
              end
            end
          end
          cur_ph  = ph;
          cur_len = 1;
        end else begin
          cur_len++;
        end
        vectors++;
        if (m_st === 1'b0) begin
          if (word_q.size() == 0) begin
            miscompares++;
            $display("FAIL hs_word_unexpected: data %h rdy %b err %b", m_sd, m_rdy, m_er);
          end else begin
            w = word_q.pop_front();
            if (m_sd !== w.d || m_rdy !== w.r || m_er !== w.e) begin
              miscompares++;
              $display("FAIL hs_word: data %h rdy %b err %b, required data %h rdy %b err %b",
                       m_sd, m_rdy, m_er, w.d, w.r, w.e);
            end
          end
        end else if (m_sd !== 8'h00 || m_rdy !== 1'b0 || m_er !== 1'b0 || m_st !== 1'b1) begin
          miscompares++;
          $display("FAIL lp_idle_outputs: data %h rdy %b err %b t %b, required 00 0 0 1", m_sd, m_rdy, m_er, m_st);
        end
      end
    end
  end

  task automatic push_run(input logic [3:0] ph, input int len);
    run_t r;
    r.ph = ph;
    r.len = len;
    run_q.push_back(r);
  endtask

  task automatic push_word(input logic [7:0] d, input logic r, input logic e);
    word_t w;
    w.d = d;
    w.r = r;
    w.e = e;
    word_q.push_back(w);
  endtask

  // n payload bytes from pay[]; last marks pay[n-1] with in_last, otherwise in_valid drops after it
  task automatic burst(input int n, input bit last, input int idle_len, input bit hold,
                       input logic [7:0] nxt, input bit abort);
    logic lb;
    bit   uf;
    int   i;
    uf = !(last && n > 0);
    lb = (n > 0) ? pay[n-1][7] : 1'b1;
    push_run(PH_IDLE, idle_len);
    push_run(PH_LPX, t_lpx[sel]);
    push_run(PH_PREP, t_prep[sel]);
    push_run(PH_HS, t_zero[sel] + 1 + n + (abort ? 0 : t_trail[sel]));
    if (!abort) push_run(PH_EXIT, t_exit[sel]);
    for (int z = 0; z < t_zero[sel]; z++) push_word(8'h00, 1'b0, 1'b0);
    push_word(8'hB8, 1'b1, 1'b0);
    for (int j = 0; j < n; j++) push_word(pay[j], !(last && j == n - 1), 1'b0);
    if (!abort)
      for (int t = 0; t < t_trail[sel]; t++) push_word({8{~lb}}, 1'b0, (t == 0) && uf);

    in_valid = 1'b1;
    in_data  = (n > 0) ? pay[0] : 8'h00;
    in_last  = last && (n == 1);
    if (n == 0) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      i = 0;
      for (int c = 0; c < 3000 && i < n; c++) begin
        @(negedge clk);
        if (m_rdy === 1'b1) begin
          @(posedge clk); #1;
          i++;
          if (i < n) begin
            in_data = pay[i];
            in_last = last && (i == n - 1);
          end else if (hold) begin
            in_data = nxt;
            in_last = 1'b0;
          end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
          end
        end
      end
      vectors++;
      if (i < n) begin
        miscompares++;
        $display("FAIL handshake_timeout: %0d bytes accepted, required %0d", i, n);
      end
    end
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (m_hs === 1'b0) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL idle_timeout: hs_active %b, required 0", m_hs);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h93;
    burst(3, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    pay[0] = 8'h05;
    burst(1, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    pay[0] = 8'hAA; pay[1] = 8'h7F;
    burst(2, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    burst(0, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    pay[0] = 8'h31; pay[1] = 8'h42;
    burst(2, 1'b0, -1, 1'b1, 8'h53, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);

    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h93;
    burst(3, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    burst(3, 1'b1, -1, 1'b1, 8'h11, 1'b0);
    burst(3, 1'b1, 1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    sel = 2'd1;
    repeat (2) @(negedge clk);
    pay[0] = 8'hC3; pay[1] = 8'h3C;
    burst(2, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();
    pay[0] = 8'h80;
    burst(1, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    sel = 2'd2;
    repeat (2) @(negedge clk);
    pay[0] = 8'h5A;
    burst(1, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    wait_idle();

    repeat (4) @(negedge clk);
    vectors++;
    if (run_q.size() != 0 || word_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expectations: %0d runs %0d words pending, required 0 0", run_q.size(), word_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
